// File: rtl/fullchip_inst_seq_if.sv
// Bus between a host and the fullchip instruction sequencer: start/abort request side
// and the 17-bit inst stream with its status flags.
interface fullchip_inst_seq_if;
  logic        start;
  logic [4:0]  n_q;
  logic        abort;
  logic [16:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  modport master (input start, n_q, abort, output inst, busy, done, err);
  modport slave  (output start, n_q, abort, input inst, busy, done, err);
endinterface

// File: rtl/fullchip_inst_seq.sv
// Instruction sequencer for fullchip: K load, execute, then ofifo-to-pmem drain,
// ending with a one-cycle done pulse (plus err when the requested n_q is illegal).
module fullchip_inst_seq #(
  parameter int col      = 8,
  parameter int max_q    = 8,
  parameter int load_gap = 11,
  parameter int exe_gap  = 11
) (
  input  logic              clk,
  input  logic              reset,
  fullchip_inst_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, KLOAD, KHOLD, GAP_K, EXEC, GAP_E, DRAIN, DONE
  } state_t;

  state_t     state, nxt_state;
  logic [4:0] cnt, nxt_cnt;
  logic [4:0] nq;
  logic       legal;

  // inst layout: {ofifo_rd, qkmem_add[3:0], pmem_add[3:0], execute, load,
  //               qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}
  function automatic logic [16:0] word(state_t s, logic [4:0] idx);
    logic [16:0] w;
    w = '0;
    case (s)
      KLOAD: begin
        w[6] = 1'b1;
        if (idx != 5'd0) begin
          w[3]     = 1'b1;
          w[15:12] = 4'(idx - 5'd1);
        end
      end
      KHOLD: w[6] = 1'b1;
      EXEC: begin
        w[7]     = 1'b1;
        w[5]     = 1'b1;
        w[15:12] = idx[3:0];
      end
      DRAIN: begin
        w[16]   = 1'b1;
        w[0]    = 1'b1;
        w[11:8] = idx[3:0];
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  assign legal = (bus.n_q != 5'd0) && (int'(bus.n_q) <= max_q);

  // The counter restarts at zero on every state entry and indexes the words within a state.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 5'd1;
    if (bus.abort && state != DONE) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_cnt = '0;
          if (bus.start) nxt_state = legal ? KLOAD : DONE;
        end
        KLOAD: if (int'(cnt) == col) begin
          nxt_state = KHOLD;
          nxt_cnt   = '0;
        end
        KHOLD: begin
          nxt_state = (load_gap == 0) ? EXEC : GAP_K;
          nxt_cnt   = '0;
        end
        GAP_K: if (int'(cnt) == load_gap - 1) begin
          nxt_state = EXEC;
          nxt_cnt   = '0;
        end
        EXEC: if (int'(cnt) == int'(nq) - 1) begin
          nxt_state = (exe_gap == 0) ? DRAIN : GAP_E;
          nxt_cnt   = '0;
        end
        GAP_E: if (int'(cnt) == exe_gap - 1) begin
          nxt_state = DRAIN;
          nxt_cnt   = '0;
        end
        DRAIN: if (int'(cnt) == int'(nq) - 1) begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so each word appears with its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      nq       <= '0;
      bus.inst <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      if (state == IDLE) nq <= bus.n_q;
      bus.inst <= word(nxt_state, nxt_cnt);
      bus.busy <= (nxt_state != IDLE) && (nxt_state != DONE);
      bus.done <= (nxt_state == DONE);
      bus.err  <= (state == IDLE) && (nxt_state == DONE);
    end
  end

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// Self-checking bench for fullchip_inst_seq: table vectors, random runs against a
// stream model, plus abort, mid-run reset and back-to-back start sequences.
module tb_fullchip_inst_seq;
  localparam int COL      = 8;
  localparam int MAX_Q    = 8;
  localparam int LOAD_GAP = 11;
  localparam int EXE_GAP  = 11;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [16:0] exp_q[$];

  fullchip_inst_seq_if bus();

  fullchip_inst_seq #(
    .col(COL), .max_q(MAX_Q), .load_gap(LOAD_GAP), .exe_gap(EXE_GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nq;
    bit exp_err;
    int exp_len;
  } vec_t;

  function automatic logic [16:0] mk(bit ofifo, int qk, int pm, bit exe, bit ld,
                                      bit qrd, bit krd, bit pwr);
    logic [3:0] q4;
    logic [3:0] p4;
    q4 = 4'(qk);
    p4 = 4'(pm);
    return {ofifo, q4, p4, exe, ld, qrd, 1'b0, krd, 1'b0, 1'b0, pwr};
  endfunction

  // The full expected command stream for one legal run; empty when n_q is illegal.
  function automatic void build_stream(int nq);
    exp_q.delete();
    if (nq < 1 || nq > MAX_Q) return;
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    for (int a = 0; a < COL; a++) exp_q.push_back(mk(0, a, 0, 0, 1, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    for (int g = 0; g < LOAD_GAP; g++) exp_q.push_back(17'd0);
    for (int j = 0; j < nq; j++) exp_q.push_back(mk(0, j, 0, 1, 0, 1, 0, 0));
    for (int g = 0; g < EXE_GAP; g++) exp_q.push_back(17'd0);
    for (int j = 0; j < nq; j++) exp_q.push_back(mk(1, 0, j, 0, 0, 0, 0, 1));
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(bit s, int nq);
    bus.start = s;
    bus.n_q   = 5'(nq);
  endtask

  task automatic run_once(int nq, bit exp_err, int exp_len, string tag);
    int done_at;
    done_at = 0;
    build_stream(nq);
    apply_stimulus(1'b1, nq);
    @(negedge clk);
    apply_stimulus(1'b0, nq);
    for (int k = 1; k <= exp_len + 20; k++) begin
      if (bus.done) begin
        done_at = k;
        break;
      end
      if (k - 1 < exp_q.size()) begin
        check_output({tag, "_inst"}, 32'(bus.inst), 32'(exp_q[k-1]));
        check_output({tag, "_busy"}, 32'(bus.busy), 32'd1);
      end else begin
        check_output({tag, "_overrun"}, k, exp_q.size());
      end
      @(negedge clk);
    end
    check_output({tag, "_done_cycle"}, done_at, exp_len + 1);
    if (done_at != 0) begin
      check_output({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      check_output({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      check_output({tag, "_inst_at_done"}, 32'(bus.inst), 32'd0);
    end
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check_output({tag, "_err_pulse"}, 32'(bus.err), 32'd0);
  endtask

  // Cut a legal run short after `cut` words, by abort or by asynchronous reset.
  task automatic run_cut(int nq, int cut, bit use_reset, string tag);
    bit seen_done;
    bit seen_inst;
    build_stream(nq);
    apply_stimulus(1'b1, nq);
    @(negedge clk);
    apply_stimulus(1'b0, nq);
    for (int k = 1; k <= cut; k++) begin
      if (k > 1) @(negedge clk);
      check_output({tag, "_inst"}, 32'(bus.inst), 32'(exp_q[k-1]));
    end
    if (use_reset) begin
      reset = 1'b0;
      #1;
      check_output({tag, "_rst_inst"}, 32'(bus.inst), 32'd0);
      check_output({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
      check_output({tag, "_rst_done"}, 32'(bus.done), 32'd0);
      @(negedge clk);
      reset = 1'b1;
    end else begin
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_output({tag, "_abort_inst"}, 32'(bus.inst), 32'd0);
      check_output({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
    end
    seen_done = 1'b0;
    seen_inst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      if (bus.inst != 17'd0 || bus.busy) seen_inst = 1'b1;
    end
    check_output({tag, "_no_done"}, 32'(seen_done), 32'd0);
    check_output({tag, "_stays_idle"}, 32'(seen_inst), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   nq;
    bit   e;

    vecs[0] = '{8, 1'b0, 48};
    vecs[1] = '{1, 1'b0, 34};
    vecs[2] = '{0, 1'b1, 0};
    vecs[3] = '{9, 1'b1, 0};
    vecs[4] = '{4, 1'b0, 40};
    vecs[5] = '{31, 1'b1, 0};
    vecs[6] = '{2, 1'b0, 36};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.n_q   = 5'd0;
    bus.abort = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("reset_inst", 32'(bus.inst), 32'd0);
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_err",  32'(bus.err),  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      run_once(vecs[v].nq, vecs[v].exp_err, vecs[v].exp_len, $sformatf("vec%0d", v));

    // Abort in EXEC j=3 (cycle 25), then a fresh default run must be identical.
    run_cut(8, 25, 1'b0, "abort_exec3");
    run_once(8, 1'b0, 48, "after_abort");

    // Asynchronous reset in DRAIN (cycle 43), then a fresh default run.
    run_cut(8, 43, 1'b1, "reset_drain");
    run_once(8, 1'b0, 48, "after_reset");

    // start held high: back-to-back identical runs with one IDLE cycle between.
    build_stream(8);
    apply_stimulus(1'b1, 8);
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 48; k++) begin
        check_output($sformatf("b2b%0d_inst", r), 32'(bus.inst), 32'(exp_q[k]));
        @(negedge clk);
      end
      check_output($sformatf("b2b%0d_done", r), 32'(bus.done), 32'd1);
      @(negedge clk);
      check_output($sformatf("b2b%0d_idle_busy", r), 32'(bus.busy), 32'd0);
      check_output($sformatf("b2b%0d_idle_inst", r), 32'(bus.inst), 32'd0);
      check_output($sformatf("b2b%0d_idle_done", r), 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    apply_stimulus(1'b0, 8);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_output("b2b_abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);

    for (int t = 0; t < 16; t++) begin
      nq = int'($urandom_range(0, 20));
      e  = (nq == 0) || (nq > MAX_Q);
      run_once(nq, e, e ? 0 : COL + 2 + LOAD_GAP + 2 * nq + EXE_GAP,
               $sformatf("rand%0d_n%0d", t, nq));
    end

    for (int t = 0; t < 4; t++) begin
      nq = int'($urandom_range(1, MAX_Q));
      run_cut(nq, int'($urandom_range(1, COL + 2 + LOAD_GAP + 2 * nq + EXE_GAP)),
              t[0], $sformatf("rcut%0d_n%0d", t, nq));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
